// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage register with flush and stall statistics
// Ring buffer between two CPU stages; in_ready never depends on out_ready, so no ready loop forms.
module pipe_stage_elastic #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  stall_cycles,
  input  logic                         clr_stats
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign in_ready  = (count < FULL) && !flush && !RST;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_data  = out_valid ? head : BUBBLE_VALUE;

  // Flush and reset both discard held entries; push is already blocked via in_ready.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (DEPTH == 1) begin : g_latch
      logic [WIDTH-1:0] hold;
      always_ff @(posedge CLK) begin
        if (push) begin
          hold <= in_data;
        end
      end
      assign head = hold;
    end else begin : g_ring
      logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge CLK) begin
        if (push) begin
          mem[wptr] <= in_data;
        end
      end
      assign head = mem[rptr];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST || clr_stats) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - bench for pipe_stage_elastic at DEPTH 2, 3 and 1
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] BB = 32'hBBBB_0000;

  logic        rst_a, flush_a, iv_a, ir_a, ov_a, or_a, clr_a;
  logic [31:0] id_a, od_a;
  logic [1:0]  cnt_a;
  logic [15:0] st_a;

  logic        rst_b, flush_b, iv_b, ir_b, ov_b, or_b, clr_b;
  logic [31:0] id_b, od_b;
  logic [1:0]  cnt_b;
  logic [15:0] st_b;

  logic        rst_c, flush_c, iv_c, ir_c, ov_c, or_c, clr_c;
  logic [31:0] id_c, od_c;
  logic [0:0]  cnt_c;
  logic [15:0] st_c;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .BUBBLE_VALUE(32'h0)) dut_a (
    .CLK(clk), .RST(rst_a), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .count(cnt_a), .stall_cycles(st_a), .clr_stats(clr_a));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .BUBBLE_VALUE(BB)) dut_b (
    .CLK(clk), .RST(rst_b), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .count(cnt_b), .stall_cycles(st_b), .clr_stats(clr_b));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(1), .BUBBLE_VALUE(32'h0)) dut_c (
    .CLK(clk), .RST(rst_c), .flush(flush_c), .in_valid(iv_c), .in_ready(ir_c),
    .in_data(id_c), .out_valid(ov_c), .out_ready(or_c), .out_data(od_c),
    .count(cnt_c), .stall_cycles(st_c), .clr_stats(clr_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        rst, flush, iv, ordy, clr;
    logic [31:0] din;
    logic        ir, ov;
    logic [31:0] dout;
    logic [1:0]  cnt;
    logic [15:0] stall;
  } vec_t;

  vec_t        tbl [0:21];
  logic [31:0] q [$];
  int          stall_m;
  int          nextv;
  logic        e_ir, e_ov;
  logic [31:0] e_od;

  initial begin
    // DEPTH=3: reset, backpressure/full, pointer wrap, flush, clr_stats, mid-run reset
    tbl[0]  = '{1,0,1,0,0,32'hDEAD, 0,0,BB,      0,0};
    tbl[1]  = '{1,0,1,0,0,32'hDEAD, 0,0,BB,      0,0};
    tbl[2]  = '{0,0,1,0,0,32'hA,    1,0,BB,      0,0};
    tbl[3]  = '{0,0,1,0,0,32'hB,    1,1,32'hA,   1,0};
    tbl[4]  = '{0,0,1,0,0,32'hC,    1,1,32'hA,   2,1};
    tbl[5]  = '{0,0,1,0,0,32'hD,    0,1,32'hA,   3,2};
    tbl[6]  = '{0,0,1,1,0,32'hD,    0,1,32'hA,   3,3};
    tbl[7]  = '{0,0,1,1,0,32'hD,    1,1,32'hB,   2,3};
    tbl[8]  = '{0,0,0,1,0,32'h0,    1,1,32'hC,   2,3};
    tbl[9]  = '{0,0,0,1,0,32'h0,    1,1,32'hD,   1,3};
    tbl[10] = '{0,0,0,0,0,32'h0,    1,0,BB,      0,3};
    tbl[11] = '{0,0,1,0,0,32'h11,   1,0,BB,      0,3};
    tbl[12] = '{0,0,1,0,0,32'h22,   1,1,32'h11,  1,3};
    tbl[13] = '{0,1,1,1,0,32'h33,   0,1,32'h11,  2,4};
    tbl[14] = '{0,0,0,0,0,32'h0,    1,0,BB,      0,4};
    tbl[15] = '{0,0,0,0,1,32'h0,    1,0,BB,      0,4};
    tbl[16] = '{0,0,1,0,0,32'h44,   1,0,BB,      0,0};
    tbl[17] = '{0,0,0,1,0,32'h0,    1,1,32'h44,  1,0};
    tbl[18] = '{0,0,1,0,0,32'h55,   1,0,BB,      0,0};
    tbl[19] = '{0,0,0,0,0,32'h0,    1,1,32'h55,  1,0};
    tbl[20] = '{1,0,0,0,0,32'h0,    0,1,32'h55,  1,1};
    tbl[21] = '{0,0,0,0,0,32'h0,    1,0,BB,      0,0};

    rst_a = 1; flush_a = 0; iv_a = 1; id_a = 32'hDEAD; or_a = 0; clr_a = 0;
    rst_b = 1; flush_b = 0; iv_b = 0; id_b = 0;        or_b = 0; clr_b = 0;
    rst_c = 1; flush_c = 0; iv_c = 1; id_c = 32'hDEAD; or_c = 0; clr_c = 0;

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_a_ir", ir_a, 0);
      chk("rst_a_ov", ov_a, 0);
      chk("rst_a_od", od_a, 0);
      chk("rst_a_cnt", cnt_a, 0);
      chk("rst_a_st", st_a, 0);
      chk("rst_c_ir", ir_c, 0);
      chk("rst_c_cnt", cnt_c, 0);
      step();
    end
    rst_a = 0; iv_a = 0; rst_c = 0; iv_c = 0;
    @(negedge clk);
    chk("rel_a_ir", ir_a, 1);
    chk("rel_c_ir", ir_c, 1);

    for (int i = 0; i < 22; i++) begin
      rst_b = tbl[i].rst; flush_b = tbl[i].flush; iv_b = tbl[i].iv;
      or_b = tbl[i].ordy; clr_b = tbl[i].clr; id_b = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl%0d_ir", i), ir_b, tbl[i].ir);
      chk($sformatf("tbl%0d_ov", i), ov_b, tbl[i].ov);
      chk($sformatf("tbl%0d_od", i), od_b, tbl[i].dout);
      chk($sformatf("tbl%0d_cnt", i), cnt_b, tbl[i].cnt);
      chk($sformatf("tbl%0d_st", i), st_b, tbl[i].stall);
      step();
    end

    // DEPTH=2 streaming: one bundle per cycle, one cycle latency
    or_a = 1;
    for (int k = 0; k < 9; k++) begin
      iv_a = (k < 8); id_a = k + 1;
      @(negedge clk);
      chk($sformatf("str%0d_ir", k), ir_a, 1);
      chk($sformatf("str%0d_cnt", k), cnt_a, (k == 0) ? 0 : 1);
      chk($sformatf("str%0d_ov", k), ov_a, (k != 0));
      if (k > 0) chk($sformatf("str%0d_od", k), od_a, k);
      step();
    end
    iv_a = 0;

    // DEPTH=1: in_ready alternates, one transfer per two cycles
    or_c = 1; iv_c = 1; nextv = 1;
    for (int k = 0; k < 10; k++) begin
      id_c = nextv;
      @(negedge clk);
      chk($sformatf("d1_%0d_ir", k), ir_c, (k % 2 == 0));
      chk($sformatf("d1_%0d_ov", k), ov_c, (k % 2 == 1));
      if (k % 2 == 1) chk($sformatf("d1_%0d_od", k), od_c, (k + 1) / 2);
      if (iv_c && ir_c) nextv++;
      step();
    end
    iv_c = 0;

    // Stall counter saturation and clear on DEPTH=3
    iv_b = 1; id_b = 32'h77; or_b = 0;
    step();
    iv_b = 0;
    repeat (70000) step();
    @(negedge clk);
    chk("sat_ov", ov_b, 1);
    chk("sat_st", st_b, 16'hFFFF);
    step();
    clr_b = 1;
    @(negedge clk);
    chk("sat_hold", st_b, 16'hFFFF);
    step();
    clr_b = 0;
    @(negedge clk);
    chk("clr_st", st_b, 0);
    step();
    @(negedge clk);
    chk("resume_st", st_b, 1);
    chk("resume_od", od_b, 32'h77);

    // Randomized DEPTH=2 run against a queue model
    step();
    q.delete();
    stall_m = 0;
    rst_a = 1; iv_a = 0; or_a = 0; flush_a = 0; clr_a = 0;
    step();
    for (int k = 0; k < 3000; k++) begin
      rst_a   = ($urandom_range(0, 199) == 0);
      flush_a = ($urandom_range(0, 29) == 0);
      iv_a    = $urandom_range(0, 1);
      or_a    = ($urandom_range(0, 3) != 0);
      clr_a   = ($urandom_range(0, 99) == 0);
      id_a    = $urandom;
      e_ir = (q.size() < 2) && !flush_a && !rst_a;
      e_ov = (q.size() != 0);
      e_od = 32'h0;
      if (e_ov) e_od = q[0];
      @(negedge clk);
      chk("rnd_ir", ir_a, e_ir);
      chk("rnd_ov", ov_a, e_ov);
      chk("rnd_od", od_a, e_od);
      chk("rnd_cnt", cnt_a, q.size());
      chk("rnd_st", st_a, stall_m);
      if (rst_a) begin
        q.delete();
        stall_m = 0;
      end else begin
        if (clr_a) stall_m = 0;
        else if (e_ov && !or_a && !flush_a && stall_m < 65535) stall_m++;
        if (flush_a) q.delete();
        else begin
          if (e_ov && or_a) void'(q.pop_front());
          if (iv_a && e_ir) q.push_back(id_a);
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
